// File: rtl/multicycle_control_unit.sv
// Multi-cycle control unit for the RV32-subset datapath. It sequences
// FETCH/DECODE/EXECUTE/MEM/WB over one shared memory port and holds the
// instruction register. Illegal encodings and memory stalls longer than
// TIMEOUT_CYCLES park the machine in TRAP until reset. Every retired
// instruction is counted.
//
// state   | meaning
// --------+-----------------------------------------------------------
// FETCH   | read instruction at PC, load IR and bump PC on mem_ready
// DECODE  | classify IR, latch the decode, trap on illegal encodings
// EXECUTE | drive ALU/immediate/branch controls for one cycle
// MEM     | data access at the ALU address (lw read, sw write)
// WB      | register-file write (suppressed for jal)
// TRAP    | illegal instruction or memory timeout; exits only on reset
module multicycle_control_unit #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      mem_rdata,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             addr_sel,
    output logic [31:0]      ir,
    output logic             ir_write,
    output logic             pc_write,
    output logic             reg_write,
    output logic             mem_to_reg,
    output logic [2:0]       alu_control,
    output logic             alu_src,
    output logic [1:0]       imm_control,
    output logic             slt,
    output logic             auipc,
    output logic             branch_beq,
    output logic             branch_jal,
    output logic             branch_jalr,
    output logic [2:0]       state,
    output logic             illegal,
    output logic             timeout,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        FETCH   = 3'd0,
        DECODE  = 3'd1,
        EXECUTE = 3'd2,
        MEM     = 3'd3,
        WB      = 3'd4,
        TRAP    = 3'd5
    } stateT;

    typedef struct packed {
        logic [2:0] alu;
        logic       aluSrc;
        logic [1:0] imm;
        logic       slt;
        logic       auipc;
        logic       beq;
        logic       jal;
        logic       jalr;
        logic       lw;
        logic       sw;
        logic       legal;
    } decodeT;

    // The wait counter only needs to reach TIMEOUT_CYCLES-1: the cycle that
    // would make it TIMEOUT_CYCLES is the one that traps instead.
    localparam int WAIT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST =
        WAIT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

    stateT             stateQ;
    logic [31:0]       irQ;
    decodeT            dec;
    decodeT            decQ;
    logic [WAIT_W-1:0] waitCnt;
    logic              waitHit;
    logic              illegalQ;
    logic              timeoutQ;
    logic [CNT_W-1:0]  retiredQ;
    logic              fetching;

    // Instruction decode of the held IR; latched into decQ during DECODE.
    always_comb begin
        dec       = '0;
        dec.legal = 1'b1;
        unique case (irQ[6:0])
            7'b0110011: begin
                if (irQ[31:25] == 7'b0000000) begin
                    unique case (irQ[14:12])
                        3'b000:  dec.alu = 3'b000;
                        3'b010:  begin dec.alu = 3'b110; dec.slt = 1'b1; end
                        3'b111:  dec.alu = 3'b010;
                        3'b001:  dec.alu = 3'b011;
                        3'b101:  dec.alu = 3'b100;
                        default: dec.legal = 1'b0;
                    endcase
                end else if (irQ[31:25] == 7'b0100000) begin
                    unique case (irQ[14:12])
                        3'b000:  dec.alu = 3'b001;
                        3'b101:  dec.alu = 3'b101;
                        default: dec.legal = 1'b0;
                    endcase
                end else begin
                    dec.legal = 1'b0;
                end
            end
            7'b0010011: begin dec.imm = 2'b01; dec.aluSrc = 1'b1; end
            7'b0100011: begin dec.imm = 2'b01; dec.aluSrc = 1'b1; dec.sw = 1'b1; end
            7'b0000011: begin dec.aluSrc = 1'b1; dec.lw = 1'b1; end
            7'b1100011: begin dec.alu = 3'b001; dec.beq = 1'b1; end
            7'b1101111: begin dec.imm = 2'b11; dec.jal = 1'b1; end
            7'b0110111: dec.imm = 2'b10;
            7'b1100111: begin dec.imm = 2'b01; dec.aluSrc = 1'b1; dec.jalr = 1'b1; end
            7'b0001011: dec.alu = 3'b111;
            7'b0010111: dec.auipc = 1'b1;
            default:    dec.legal = 1'b0;
        endcase
    end

    assign waitHit = TIMEOUT_EN && (waitCnt == WAIT_LAST);

    // Sequencer: state, IR, latched decode, wait timer, sticky flags and retire count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ   <= FETCH;
            irQ      <= '0;
            decQ     <= '0;
            waitCnt  <= '0;
            illegalQ <= 1'b0;
            timeoutQ <= 1'b0;
            retiredQ <= '0;
        end else begin
            unique case (stateQ)
                FETCH: begin
                    if (mem_ready) begin
                        irQ    <= mem_rdata;
                        stateQ <= DECODE;
                    end else if (waitHit) begin
                        timeoutQ <= 1'b1;
                        stateQ   <= TRAP;
                    end else begin
                        waitCnt <= waitCnt + WAIT_W'(1);
                    end
                end
                DECODE: begin
                    decQ <= dec;
                    if (!dec.legal) begin
                        illegalQ <= 1'b1;
                        stateQ   <= TRAP;
                    end else begin
                        stateQ <= EXECUTE;
                    end
                end
                EXECUTE: begin
                    if (decQ.lw || decQ.sw) begin
                        waitCnt <= '0;
                        stateQ  <= MEM;
                    end else if (decQ.beq) begin
                        waitCnt  <= '0;
                        retiredQ <= retiredQ + CNT_W'(1);
                        stateQ   <= FETCH;
                    end else begin
                        stateQ <= WB;
                    end
                end
                MEM: begin
                    if (mem_ready) begin
                        if (decQ.sw) begin
                            waitCnt  <= '0;
                            retiredQ <= retiredQ + CNT_W'(1);
                            stateQ   <= FETCH;
                        end else begin
                            stateQ <= WB;
                        end
                    end else if (waitHit) begin
                        timeoutQ <= 1'b1;
                        stateQ   <= TRAP;
                    end else begin
                        waitCnt <= waitCnt + WAIT_W'(1);
                    end
                end
                WB: begin
                    waitCnt  <= '0;
                    retiredQ <= retiredQ + CNT_W'(1);
                    stateQ   <= FETCH;
                end
                TRAP:    stateQ <= TRAP;
                default: stateQ <= TRAP;
            endcase
        end
    end

    // Reset parks the machine in FETCH, so the FETCH strobes are qualified
    // with rst_n to keep the memory port quiet while reset is held.
    assign fetching    = rst_n && (stateQ == FETCH);
    assign mem_req     = fetching || (stateQ == MEM);
    assign addr_sel    = (stateQ == MEM);
    assign mem_we      = (stateQ == MEM) && decQ.sw;
    assign ir_write    = fetching && mem_ready;
    assign pc_write    = fetching && mem_ready;
    assign reg_write   = (stateQ == WB) && !decQ.jal;
    assign mem_to_reg  = (stateQ == WB) && decQ.lw;
    assign alu_control = (stateQ == EXECUTE || stateQ == MEM) ? decQ.alu : 3'b000;
    assign alu_src     = (stateQ == EXECUTE || stateQ == MEM) && decQ.aluSrc;
    assign imm_control = (stateQ == EXECUTE) ? decQ.imm : 2'b00;
    assign slt         = (stateQ == EXECUTE) && decQ.slt;
    assign auipc       = (stateQ == EXECUTE) && decQ.auipc;
    assign branch_beq  = (stateQ == EXECUTE) && decQ.beq;
    assign branch_jal  = (stateQ == EXECUTE) && decQ.jal;
    assign branch_jalr = (stateQ == EXECUTE) && decQ.jalr;
    assign state       = stateQ;
    assign ir          = irQ;
    assign illegal     = illegalQ;
    assign timeout     = timeoutQ;
    assign retired     = retiredQ;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit (TIMEOUT_CYCLES=4, CNT_W=4). Each cycle
// the expected strobe/state picture is queued as stimulus is driven and
// popped for comparison once the DUT outputs settle.
module tb_multicycle_control_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] mem_rdata = '0;
    logic        mem_ready = 1'b0;
    logic        mem_req, mem_we, addr_sel, ir_write, pc_write, reg_write, mem_to_reg;
    logic [31:0] ir;
    logic [2:0]  alu_control;
    logic        alu_src;
    logic [1:0]  imm_control;
    logic        slt, auipc, branch_beq, branch_jal, branch_jalr;
    logic [2:0]  state;
    logic        illegal, timeout;
    logic [3:0]  retired;

    multicycle_control_unit #(.TIMEOUT_CYCLES(4), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel), .ir(ir),
        .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
        .mem_to_reg(mem_to_reg), .alu_control(alu_control), .alu_src(alu_src),
        .imm_control(imm_control), .slt(slt), .auipc(auipc),
        .branch_beq(branch_beq), .branch_jal(branch_jal), .branch_jalr(branch_jalr),
        .state(state), .illegal(illegal), .timeout(timeout), .retired(retired)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] st;
        logic req, we, asel, irw, pcw, rw, m2r;
        logic [2:0] alu;
        logic asrc;
        logic [1:0] imm;
        logic slt, auipc, beq, jal, jalr;
    } obsT;

    localparam int K_ALU = 0, K_LW = 1, K_SW = 2, K_BEQ = 3, K_JAL = 4;

    obsT got;
    assign got = {state, mem_req, mem_we, addr_sel, ir_write, pc_write, reg_write,
                  mem_to_reg, alu_control, alu_src, imm_control, slt, auipc,
                  branch_beq, branch_jal, branch_jalr};

    obsT        sb[$];
    int         checks = 0;
    int         errors = 0;
    logic [3:0] expRet = '0;

    function automatic obsT fetchObs(input logic rdy);
        obsT o = '0;
        o.st = 3'd0; o.req = 1'b1; o.irw = rdy; o.pcw = rdy;
        return o;
    endfunction

    function automatic obsT decodeObs();
        obsT o = '0;
        o.st = 3'd1;
        return o;
    endfunction

    // modes = {slt, auipc, beq, jal, jalr}
    function automatic obsT execObs(input logic [2:0] alu, input logic asrc,
                                    input logic [1:0] imm, input logic [4:0] modes);
        obsT o = '0;
        o.st = 3'd2; o.alu = alu; o.asrc = asrc; o.imm = imm;
        {o.slt, o.auipc, o.beq, o.jal, o.jalr} = modes;
        return o;
    endfunction

    function automatic obsT memObs(input logic we, input logic [2:0] alu, input logic asrc);
        obsT o = '0;
        o.st = 3'd3; o.req = 1'b1; o.asel = 1'b1; o.we = we; o.alu = alu; o.asrc = asrc;
        return o;
    endfunction

    function automatic obsT wbObs(input logic rw, input logic m2r);
        obsT o = '0;
        o.st = 3'd4; o.rw = rw; o.m2r = m2r;
        return o;
    endfunction

    function automatic obsT trapObs();
        obsT o = '0;
        o.st = 3'd5;
        return o;
    endfunction

    task automatic step(input logic rdy, input logic [31:0] rd, input obsT e, input string name);
        obsT x;
        @(negedge clk);
        mem_ready = rdy;
        mem_rdata = rd;
        sb.push_back(e);
        #1;
        x = sb.pop_front();
        checks++;
        if (got !== x) begin
            errors++;
            $display("FAIL %s cycle: got %h expected %h (t=%0t)", name, got, x, $time);
        end
    endtask

    task automatic checkRetired(input string name);
        @(posedge clk);
        #1;
        mem_ready = 1'b0;
        checks++;
        if (retired !== expRet) begin
            errors++;
            $display("FAIL %s retired: got %0d expected %0d", name, retired, expRet);
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n = 1'b0;
        mem_ready = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        expRet = '0;
    endtask

    task automatic doInstr(input logic [31:0] instr, input int kind, input obsT ex,
                           input int fetchWait, input int memWait, input logic spur,
                           input string name);
        for (int i = 0; i < fetchWait; i++) step(1'b0, 32'hDEADBEEF, fetchObs(1'b0), name);
        step(1'b1, instr, fetchObs(1'b1), name);
        step(spur, 32'hFFFFFFFF, decodeObs(), name);
        checks++;
        if (ir !== instr) begin
            errors++;
            $display("FAIL %s ir: got %h expected %h", name, ir, instr);
        end
        step(spur, 32'h0, ex, name);
        if (kind == K_LW || kind == K_SW) begin
            for (int i = 0; i < memWait; i++)
                step(1'b0, 32'h0, memObs(kind == K_SW, ex.alu, ex.asrc), name);
            step(1'b1, 32'h0, memObs(kind == K_SW, ex.alu, ex.asrc), name);
            if (kind == K_LW) step(spur, 32'h0, wbObs(1'b1, 1'b1), name);
        end else if (kind == K_ALU) begin
            step(spur, 32'h0, wbObs(1'b1, 1'b0), name);
        end else if (kind == K_JAL) begin
            step(spur, 32'h0, wbObs(1'b0, 1'b0), name);
        end
        expRet++;
        checkRetired(name);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        mem_ready = 1'b1;
        mem_rdata = 32'hABCD1234;
        #12;
        checks++;
        if (got !== obsT'(0) || ir !== 32'h0 || retired !== 4'h0 ||
            illegal !== 1'b0 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL reset: obs %h ir %h ret %0d ill %b to %b expected all zero",
                     got, ir, retired, illegal, timeout);
        end
        @(posedge clk);
        #1;
        mem_ready = 1'b0;
        rst_n = 1'b1;
        expRet = '0;
    endtask

    task automatic test_alu_ops();
        doInstr(32'h00500093, K_ALU, execObs(3'b000, 1'b1, 2'b01, 5'b00000), 0, 0, 1'b0, "addi");
        doInstr(32'h40000033, K_ALU, execObs(3'b001, 1'b0, 2'b00, 5'b00000), 0, 0, 1'b0, "sub");
        doInstr(32'h00002033, K_ALU, execObs(3'b110, 1'b0, 2'b00, 5'b10000), 0, 0, 1'b1, "slt");
        doInstr(32'h00005033, K_ALU, execObs(3'b100, 1'b0, 2'b00, 5'b00000), 0, 0, 1'b0, "srl");
        doInstr(32'h00000017, K_ALU, execObs(3'b000, 1'b0, 2'b00, 5'b01000), 0, 0, 1'b0, "auipc");
        doInstr(32'h00000067, K_ALU, execObs(3'b000, 1'b1, 2'b01, 5'b00001), 0, 0, 1'b1, "jalr");
        doInstr(32'h0000000B, K_ALU, execObs(3'b111, 1'b0, 2'b00, 5'b00000), 0, 0, 1'b0, "adduqb");
        doInstr(32'h000000B7, K_ALU, execObs(3'b000, 1'b0, 2'b10, 5'b00000), 0, 0, 1'b0, "lui");
        doInstr(32'h0000006F, K_JAL, execObs(3'b000, 1'b0, 2'b11, 5'b00010), 0, 0, 1'b1, "jal");
    endtask

    task automatic test_mem_ops();
        doInstr(32'h0000A083, K_LW,  execObs(3'b000, 1'b1, 2'b00, 5'b00000), 0, 3, 1'b0, "lw");
        doInstr(32'h0010A023, K_SW,  execObs(3'b000, 1'b1, 2'b01, 5'b00000), 1, 0, 1'b0, "sw");
        doInstr(32'h00000063, K_BEQ, execObs(3'b001, 1'b0, 2'b00, 5'b00100), 0, 0, 1'b0, "beq");
    endtask

    task automatic test_illegal(input logic [31:0] instr, input string name);
        doReset();
        step(1'b1, instr, fetchObs(1'b1), name);
        step(1'b0, 32'h0, decodeObs(), name);
        for (int i = 0; i < 12; i++) step(1'(i % 2), 32'h0, trapObs(), name);
        checks++;
        if (illegal !== 1'b1 || timeout !== 1'b0 || retired !== 4'h0) begin
            errors++;
            $display("FAIL %s flags: ill %b to %b ret %0d expected ill 1 to 0 ret 0",
                     name, illegal, timeout, retired);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (illegal !== 1'b0 || state !== 3'd0) begin
            errors++;
            $display("FAIL %s clear: ill %b state %0d expected 0 0", name, illegal, state);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_timeout();
        doReset();
        for (int i = 0; i < 4; i++) step(1'b0, 32'h0, fetchObs(1'b0), "to_fetch");
        step(1'b1, 32'h00500093, trapObs(), "to_fetch");
        checks++;
        if (timeout !== 1'b1 || illegal !== 1'b0) begin
            errors++;
            $display("FAIL to_fetch flag: to %b ill %b expected 1 0", timeout, illegal);
        end
        doReset();
        doInstr(32'h00500093, K_ALU, execObs(3'b000, 1'b1, 2'b01, 5'b00000), 3, 0, 1'b0, "to_edge");
        checks++;
        if (timeout !== 1'b0) begin
            errors++;
            $display("FAIL to_edge flag: got %b expected 0", timeout);
        end
        step(1'b1, 32'h0000A083, fetchObs(1'b1), "to_mem");
        step(1'b0, 32'h0, decodeObs(), "to_mem");
        step(1'b0, 32'h0, execObs(3'b000, 1'b1, 2'b00, 5'b00000), "to_mem");
        for (int i = 0; i < 4; i++) step(1'b0, 32'h0, memObs(1'b0, 3'b000, 1'b1), "to_mem");
        step(1'b1, 32'h0, trapObs(), "to_mem");
        checks++;
        if (timeout !== 1'b1 || retired !== expRet) begin
            errors++;
            $display("FAIL to_mem flag: to %b ret %0d expected 1 %0d", timeout, retired, expRet);
        end
    endtask

    task automatic test_back_to_back();
        doReset();
        for (int n = 0; n < 17; n++)
            doInstr(32'h00500093, K_ALU, execObs(3'b000, 1'b1, 2'b01, 5'b00000), 0, 0, 1'b0, "wrap");
        checks++;
        if (retired !== 4'd1) begin
            errors++;
            $display("FAIL wrap final: got %0d expected 1", retired);
        end
    endtask

    task automatic test_reset_mid_mem();
        doReset();
        doInstr(32'h00500093, K_ALU, execObs(3'b000, 1'b1, 2'b01, 5'b00000), 0, 0, 1'b0, "pre");
        step(1'b1, 32'h0000A083, fetchObs(1'b1), "midmem");
        step(1'b0, 32'h0, decodeObs(), "midmem");
        step(1'b0, 32'h0, execObs(3'b000, 1'b1, 2'b00, 5'b00000), "midmem");
        step(1'b0, 32'h0, memObs(1'b0, 3'b000, 1'b1), "midmem");
        #2;
        rst_n = 1'b0;
        mem_ready = 1'b1;
        #1;
        checks++;
        if (state !== 3'd0 || retired !== 4'd0 || got !== obsT'(0)) begin
            errors++;
            $display("FAIL midmem reset: state %0d ret %0d obs %h expected 0 0 0",
                     state, retired, got);
        end
        @(posedge clk);
        #1;
        mem_ready = 1'b0;
        rst_n = 1'b1;
        expRet = '0;
        doInstr(32'h00500093, K_ALU, execObs(3'b000, 1'b1, 2'b01, 5'b00000), 0, 0, 1'b0, "post");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        test_reset();
        test_alu_ops();
        test_mem_ops();
        test_illegal(32'h0000007F, "ill_opcode");
        test_illegal(32'h02000033, "ill_funct7");
        test_timeout();
        test_back_to_back();
        test_reset_mid_mem();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Successor to the single-cycle decoder. Sequences a multi-cycle RV32-subset datapath through FETCH/DECODE/EXECUTE/MEM/WB over one shared memory port with a ready handshake.
- Holds the instruction register internally and decodes the same opcode set.
- Adds illegal-instruction trapping, a memory-wait timeout, and a retired-instruction counter.

Parameters:
- TIMEOUT_CYCLES, 16: max cycles waiting for mem_ready per access; 0 disables timeout.
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- mem_rdata  in  32  memory read data (instruction in FETCH).
- mem_ready  in  1  memory completes the current access this cycle.
- mem_req  out  1  memory access request.
- mem_we  out  1  write enable (sw in MEM).
- addr_sel  out  1  0 = PC address, 1 = ALU result address.
- ir  out  32  instruction register.
- ir_write  out  1  IR load strobe.
- pc_write  out  1  PC+4 update strobe.
- reg_write  out  1  register-file write.
- mem_to_reg  out  1  writeback source is memory.
- alu_control  out  3  ALU operation.
- alu_src  out  1  ALU operand B is the immediate.
- imm_control  out  2  immediate format.
- slt, auipc, branch_beq, branch_jal, branch_jalr  out  1 each  datapath mode strobes.
- state  out  3  current FSM state.
- illegal  out  1  sticky illegal-instruction flag.
- timeout  out  1  sticky memory-timeout flag.
- retired  out  CNT_W  retired-instruction count.

Behaviour:

Reset (async, rst_n=0):
- state=FETCH (0), ir=0, retired=0, illegal=0, timeout=0.
- Every strobe is 0 while reset is asserted.
- Reset mid-access aborts the access; no retire counts.

State encoding: FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WB=4, TRAP=5.

FETCH:
- mem_req=1, addr_sel=0.
- On mem_ready: ir<=mem_rdata; ir_write=1 and pc_write=1 in that same cycle; go to DECODE.

DECODE:
- One cycle, all strobes 0.
- If the opcode or funct field is outside the table below, set illegal=1 and go to TRAP; otherwise go to EXECUTE.

EXECUTE:
- alu_control, alu_src, imm_control, slt, auipc and branch_* are driven from the decode of ir for exactly this cycle.
- Next state: lw/sw → MEM; beq → FETCH (retires); jal → WB; all others → WB.

MEM:
- mem_req=1, addr_sel=1, mem_we=1 for sw only.
- alu_control and alu_src are held at their EXECUTE values.
- On mem_ready: sw → FETCH (retires); lw → WB.

WB:
- reg_write=1 for one cycle; mem_to_reg=1 for lw.
- Next state FETCH (retires).
- jal does not write back: WB with reg_write=0 (mirrors the single-cycle decode).

TRAP:
- All strobes 0. Leaves TRAP only via reset.

Decode table (default alu_control=000, imm_control=00):
- R-type 0110011, funct7=0000000: funct3 000→000, 010→110 with slt=1, 111→010, 001→011, 101→100.
- R-type 0110011, funct7=0100000: funct3 000→001, 101→101.
- Any other R-type combination is illegal.
- 0010011 addi: imm=01, alu_src=1.
- 0100011 sw: imm=01, alu_src=1.
- 0000011 lw: alu_src=1, mem_to_reg=1.
- 1100011 beq: imm=00, alu=001, branch_beq=1.
- 1101111 jal: imm=11, branch_jal=1.
- 0110111 lui: imm=10.
- 1100111 jalr: imm=01, alu_src=1, branch_jalr=1.
- 0001011 adduqb: alu=111.
- 0010111 auipc: auipc=1.
- Any other opcode is illegal.

Timeout:
- A wait counter clears on entry to FETCH or MEM and increments each cycle mem_ready=0.
- If the counter reaches TIMEOUT_CYCLES (nonzero) before mem_ready: timeout=1, go to TRAP, access dropped.
- mem_ready in the same cycle the count is reached wins; no timeout.

Retire counter:
- retired increments by 1 on each retirement (the FETCH-bound transitions from EXECUTE-beq, MEM-sw and WB).
- Wraps modulo 2^CNT_W.

Spurious handshake: mem_ready outside FETCH/MEM is ignored.

Test Plan:
- Reset, then addi x1,x0,5 (0x00500093) with mem_ready=1 immediately: states 0,1,2,4,0; reg_write=1 in WB only; alu_src=1 and imm_control=01 in EXECUTE; retired=1.
- lw 0x0000A083 with mem_ready delayed 3 cycles in MEM: mem_req and addr_sel held high for 4 cycles; then WB with mem_to_reg=1; retired=1.
- sw 0x0010A023: MEM has mem_we=1; returns to FETCH without WB; retired increments. Then beq 0x00000063: branch_beq=1, alu_control=001 in EXECUTE, direct to FETCH.
- Illegal opcode 0x0000007F and R-type funct7=0000001: illegal=1, state=5, all strobes 0 for 10+ cycles; rst_n low clears both flags.
- TIMEOUT_CYCLES=4 with mem_ready held low in FETCH: timeout=1 after 4 wait cycles, state=5. Separately, mem_ready arriving on the 4th cycle gives no timeout.
- CNT_W=4: retire 17 addi instructions → retired=1 (wrap). Assert rst_n low mid-MEM: state=0 and retired=0 asynchronously.
